mdio_master: RTL and testbench
==============================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter ClkDiv, default 25: clk_i cycles per MDC half-period; legal range 4..255.
REQ-002 SHALL have parameter PreambleBits, default 32: preamble length; legal 0..32.
REQ-003 SHALL have port clk_i  input  1  sole clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request valid.
REQ-006 SHALL have port req_ready  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_phy  input  5  PHY address.
REQ-009 SHALL have port req_reg  input  5  register address.
REQ-010 SHALL have port req_wdata  input  16  write data.
REQ-011 SHALL have port rsp_valid  output  1  response valid.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when valid&ready.
REQ-013 SHALL have port rsp_rdata  output  16  read data; 0 for writes.
REQ-014 SHALL have port mdc_o  output  1  management clock.
REQ-015 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-016 SHALL have port mdio_t_o  output  1  tristate; 1 = released (input).
REQ-017 SHALL have port mdio_i  input  1  MDIO pad value, asynchronous.

Function
REQ-018 SHALL use states IDLE, SHIFT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; acceptance captures all req_* fields and enters SHIFT next cycle.
REQ-020 Frame SHALL be Clause 22, MSB first: PreambleBits ones, ST=01, OP (01 write, 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; length PreambleBits+32 bits.
REQ-021 Write TA SHALL be driven 10; read TA and DATA SHALL have mdio_t_o=1 for all 18 bit periods.
REQ-022 Each bit period SHALL be 2*ClkDiv cycles: mdc_o low for first ClkDiv cycles, high for next ClkDiv.
REQ-023 mdio_o/mdio_t_o SHALL change only on the first cycle of a bit period (MDC falling edge or frame start).
REQ-024 mdio_i SHALL pass through a 2-flop synchroniser; read bit SHALL be sampled from the synchroniser output on the last cycle of each MDC-high phase.
REQ-025 Read DATA bits SHALL shift into rsp_rdata MSB first; TA bits SHALL be ignored.
REQ-026 After the last bit period completes, SHALL enter RESP next cycle with rsp_valid=1, mdc_o=0, mdio_t_o=1.
REQ-027 RESP SHALL hold rsp_valid and rsp_rdata stable until rsp_ready; on handshake return to IDLE next cycle.
REQ-028 Request-accept to rsp_valid latency SHALL be exactly 1 + (PreambleBits+32)*2*ClkDiv cycles.
REQ-029 req_valid in SHIFT/RESP SHALL be ignored (back-pressured); no request is ever dropped or merged.
REQ-030 Bit counter SHALL be wide enough for 64 bits; half-period counter SHALL be 8 bits and reload to 0 on phase change, no wrap beyond ClkDiv-1.
REQ-031 Idle SHALL keep mdc_o=0, mdio_o=1, mdio_t_o=1.

Reset
REQ-032 rst_i assertion SHALL asynchronously force IDLE, req_ready=1 after deassertion, rsp_valid=0, rsp_rdata=0, mdc_o=0, mdio_o=1, mdio_t_o=1, counters and synchroniser 0.
REQ-033 Reset mid-frame SHALL abort the frame with no response; first request after reset SHALL run a full frame with preamble.

Verification
REQ-034 Write: ClkDiv=4, phy=1, reg=0, wdata=0x1140 -> captured MDIO bits 32 ones, 0101 00001 00000 10 0001000101000000; rsp_valid at cycle 513 after accept; rsp_rdata=0.
REQ-035 Read: phy=7, reg=2, PHY model drives 0x0141 from TA second bit -> mdio_t_o=1 for final 18 bits, rsp_rdata=0x0141.
REQ-036 Back-pressure: rsp_ready=0 for 20 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; back-to-back request accepted cycle after handshake.
REQ-037 Reset mid-frame at bit 40 -> all outputs at reset values within same cycle, no rsp_valid; next read completes correctly.
REQ-038 PreambleBits=0, ClkDiv=255 -> frame 32 bits, latency 1+32*510 cycles, mdc_o period 510 cycles.
REQ-039 Timing check: mdio_o never toggles while mdc_o=1; mdio_i transitions during MDC-low phase never corrupt sampled data.

Source files
------------

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one request in, one frame out on MDC/MDIO,
// one response back. Read data is sampled through a 2-flop synchroniser.
module mdio_master #(
  parameter int ClkDiv       = 25,
  parameter int PreambleBits = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_t_o,
  input  logic        mdio_i
);

  localparam logic [7:0] HalfLast = 8'(ClkDiv - 1);
  localparam logic [6:0] LastBit  = 7'(PreambleBits + 31);
  localparam logic [6:0] TaBit    = 7'(PreambleBits + 14);
  localparam logic [6:0] DataBit  = 7'(PreambleBits + 16);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_e;

  state_e      state_q;
  logic [7:0]  half_q;
  logic        high_q;
  logic [6:0]  bit_q;
  logic [63:0] shreg_q;
  logic        write_q;
  logic [1:0]  sync_q;
  logic [15:0] rdata_q;
  logic        rsp_valid_q, mdc_q, mdio_q, mdio_t_q;

  logic [31:0] frame_d;
  logic [63:0] load_d;
  logic [6:0]  bit_d;

  // Whole frame (preamble included) left-aligned in a 64-bit shifter, MSB out first.
  assign frame_d = {2'b01, (req_write ? 2'b01 : 2'b10), req_phy, req_reg,
                    (req_write ? 2'b10 : 2'b11), (req_write ? req_wdata : 16'h0000)};
  assign load_d  = {32'hFFFF_FFFF, frame_d} << (32 - PreambleBits);
  assign bit_d   = bit_q + 7'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      half_q      <= 8'd0;
      high_q      <= 1'b0;
      bit_q       <= 7'd0;
      shreg_q     <= 64'd0;
      write_q     <= 1'b0;
      sync_q      <= 2'b00;
      rdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_q      <= 1'b1;
      mdio_t_q    <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], mdio_i};
      case (state_q)
        IDLE: if (req_valid) begin
          state_q  <= SHIFT;
          write_q  <= req_write;
          half_q   <= 8'd0;
          high_q   <= 1'b0;
          bit_q    <= 7'd0;
          rdata_q  <= 16'h0000;
          mdc_q    <= 1'b0;
          mdio_q   <= load_d[63];
          mdio_t_q <= 1'b0;
          shreg_q  <= {load_d[62:0], 1'b0};
        end
        SHIFT: begin
          if (half_q != HalfLast) begin
            half_q <= half_q + 8'd1;
          end else if (!high_q) begin
            half_q <= 8'd0;
            high_q <= 1'b1;
            mdc_q  <= 1'b1;
          end else begin
            // End of MDC-high: sample read data, then fall and present the next bit.
            half_q <= 8'd0;
            high_q <= 1'b0;
            mdc_q  <= 1'b0;
            if (!write_q && bit_q >= DataBit)
              rdata_q <= {rdata_q[14:0], sync_q[1]};
            if (bit_q == LastBit) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              mdio_q      <= 1'b1;
              mdio_t_q    <= 1'b1;
            end else begin
              bit_q    <= bit_d;
              mdio_q   <= shreg_q[63];
              shreg_q  <= {shreg_q[62:0], 1'b0};
              mdio_t_q <= !write_q && (bit_d >= TaBit);
            end
          end
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mdc_o     = mdc_q;
  assign mdio_o    = mdio_q;
  assign mdio_t_o  = mdio_t_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed/randomized bench for mdio_master: two instances (ClkDiv=4/Pre=32 and
// ClkDiv=255/Pre=0), a bit-list frame model and a simple PHY driving read data.
module tb_mdio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid1, req_valid2, req_write, rsp_ready, mdio_i, sel;
  logic [4:0]  req_phy, req_reg;
  logic [15:0] req_wdata;
  logic        req_ready1, rsp_valid1, mdc1, mdio1, mdt1;
  logic        req_ready2, rsp_valid2, mdc2, mdio2, mdt2;
  logic [15:0] rsp_rdata1, rsp_rdata2;

  mdio_master #(.ClkDiv(4), .PreambleBits(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
    .mdc_o(mdc1), .mdio_o(mdio1), .mdio_t_o(mdt1), .mdio_i(mdio_i));

  mdio_master #(.ClkDiv(255), .PreambleBits(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
    .mdc_o(mdc2), .mdio_o(mdio2), .mdio_t_o(mdt2), .mdio_i(mdio_i));

  logic        rdy_s, rv_s, mdc_s, mdio_s, mdt_s;
  logic [15:0] rdata_s;
  assign rdy_s   = sel ? req_ready2 : req_ready1;
  assign rv_s    = sel ? rsp_valid2 : rsp_valid1;
  assign mdc_s   = sel ? mdc2       : mdc1;
  assign mdio_s  = sel ? mdio2      : mdio1;
  assign mdt_s   = sel ? mdt2       : mdt1;
  assign rdata_s = sel ? rsp_rdata2 : rsp_rdata1;

  int checks = 0;
  int failures = 0;
  bit exp_b[$];
  bit exp_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) req_valid2 = v; else req_valid1 = v;
  endtask

  task automatic scramble_req();
    set_valid(1'($urandom_range(0, 1)));
    req_write = 1'($urandom_range(0, 1));
    req_phy   = 5'($urandom);
    req_reg   = 5'($urandom);
    req_wdata = 16'($urandom);
  endtask

  // Expected line state per bit period, straight from the Clause 22 frame layout.
  task automatic build(input int P, input bit wr, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd);
    exp_b.delete(); exp_t.delete();
    for (int i = 0; i < P; i++) begin exp_b.push_back(1); exp_t.push_back(0); end
    exp_b.push_back(0); exp_t.push_back(0);
    exp_b.push_back(1); exp_t.push_back(0);
    exp_b.push_back(!wr); exp_t.push_back(0);
    exp_b.push_back(wr);  exp_t.push_back(0);
    for (int i = 4; i >= 0; i--) begin exp_b.push_back(phy[i]); exp_t.push_back(0); end
    for (int i = 4; i >= 0; i--) begin exp_b.push_back(rg[i]); exp_t.push_back(0); end
    exp_b.push_back(1); exp_t.push_back(!wr);
    exp_b.push_back(0); exp_t.push_back(!wr);
    for (int i = 15; i >= 0; i--) begin exp_b.push_back(wr ? wd[i] : 1'b1); exp_t.push_back(!wr); end
  endtask

  task automatic run_frame(input bit s, input int C, input int P, input bit wr,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                           input logic [15:0] phy_data, input int hold, input int abort_bit);
    int n, lat_exp, lat, b, pos, e_mdc, e_bit, e_t, e_rdy, rises, e_hold, e_ab;
    logic prev_mdc;
    logic [15:0] exp_rd;
    n = P + 32; lat_exp = 1 + n * 2 * C; lat = -1;
    e_mdc = 0; e_bit = 0; e_t = 0; e_rdy = 0; rises = 0; e_hold = 0; e_ab = 0;
    prev_mdc = 1'b0;
    exp_rd = wr ? 16'h0000 : phy_data;
    sel = s;
    build(P, wr, phy, rg, wd);
    req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
    set_valid(1'b1);
    check("accept_ready", 32'(rdy_s), 32'd1);
    for (int k = 1; k <= lat_exp + 50; k++) begin
      @(negedge clk);
      scramble_req();
      rsp_ready = 1'($urandom_range(0, 1));
      if (rv_s) begin lat = k; break; end
      b = (k - 1) / (2 * C);
      pos = (k - 1) % (2 * C);
      if (b >= n) continue;
      if (b == abort_bit && pos == 0) begin
        rst = 1'b1;
        set_valid(1'b0);
        #1;
        check("abort_rsp_valid", 32'(rv_s), 32'd0);
        check("abort_rdata", 32'(rdata_s), 32'd0);
        check("abort_mdc", 32'(mdc_s), 32'd0);
        check("abort_mdio", 32'(mdio_s), 32'd1);
        check("abort_mdio_t", 32'(mdt_s), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (rv_s !== 1'b0 || mdc_s !== 1'b0 || mdt_s !== 1'b1) e_ab++;
        end
        check("abort_quiet", 32'(e_ab), 32'd0);
        check("abort_ready", 32'(rdy_s), 32'd1);
        return;
      end
      if (mdc_s !== (pos >= C)) e_mdc++;
      if (mdc_s === 1'b1 && prev_mdc === 1'b0) rises++;
      prev_mdc = mdc_s;
      if (mdt_s !== exp_t[b]) e_t++;
      if (!exp_t[b] && mdio_s !== exp_b[b]) e_bit++;
      if (rdy_s !== 1'b0) e_rdy++;
      // PHY: garbage early in MDC-low, then the real bit (TA2 = 0, then data MSB first).
      if (pos < C / 2 || wr || b < P + 15) mdio_i = 1'($urandom_range(0, 1));
      else if (b == P + 15) mdio_i = 1'b0;
      else mdio_i = phy_data[15 - (b - P - 16)];
    end
    check("latency", 32'(lat), 32'(lat_exp));
    check("mdc_shape", 32'(e_mdc), 32'd0);
    check("mdc_rises", 32'(rises), 32'(n));
    check("mdio_bits", 32'(e_bit), 32'd0);
    check("mdio_tristate", 32'(e_t), 32'd0);
    check("ready_busy", 32'(e_rdy), 32'd0);
    if (lat < 0) return;
    check("rsp_rdata", 32'(rdata_s), 32'(exp_rd));
    check("resp_lines", 32'({mdc_s, mdt_s}), 32'd1);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble_req();
      rsp_ready = 1'b0;
      if (rv_s !== 1'b1 || rdata_s !== exp_rd || rdy_s !== 1'b0) e_hold++;
    end
    if (hold > 0) check("hold_stable", 32'(e_hold), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_valid(1'b0);
    check("post_hs_valid", 32'(rv_s), 32'd0);
    check("post_hs_ready", 32'(rdy_s), 32'd1);
  endtask

  logic [4:0]  rp, rr;
  logic [15:0] rw, rd;

  initial begin
    rst = 1'b1; req_valid1 = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_phy = 5'd0; req_reg = 5'd0; req_wdata = 16'h0; rsp_ready = 1'b0;
    mdio_i = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_rdata", 32'(rsp_rdata1), 32'd0);
    check("rst_lines", 32'({mdc1, mdio1, mdt1}), 32'b011);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready1), 32'd1);
    check("idle_lines", 32'({mdc1, mdio1, mdt1}), 32'b011);
    check("idle2_lines", 32'({req_ready2, mdc2, mdio2, mdt2}), 32'b1011);

    run_frame(0, 4, 32, 1, 5'd1, 5'd0, 16'h1140, 16'h0000, 0, -1);
    run_frame(0, 4, 32, 0, 5'd7, 5'd2, 16'h0000, 16'h0141, 20, -1);
    rp = 5'($urandom); rr = 5'($urandom); rw = 16'($urandom);
    run_frame(0, 4, 32, 1, rp, rr, rw, 16'h0000, 2, -1);
    for (int i = 0; i < 2; i++) begin
      rp = 5'($urandom); rr = 5'($urandom); rd = 16'($urandom);
      run_frame(0, 4, 32, 0, rp, rr, 16'h0000, rd, 1, -1);
    end
    rp = 5'($urandom); rr = 5'($urandom); rd = 16'($urandom);
    run_frame(0, 4, 32, 0, rp, rr, 16'h0000, rd, 0, 40);
    rd = 16'($urandom);
    run_frame(0, 4, 32, 0, rp, rr, 16'h0000, rd, 0, -1);

    rp = 5'($urandom); rr = 5'($urandom); rw = 16'($urandom);
    run_frame(1, 255, 0, 1, rp, rr, rw, 16'h0000, 1, -1);
    rd = 16'($urandom);
    run_frame(1, 255, 0, 0, rp, rr, 16'h0000, rd, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
